// File: rtl/transfer_center_tx.sv
// transfer_center_tx: serializes command, length and payload bytes into reset-aligned 8-bit MSB-first frames.
module transfer_center_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter logic [7:0] CMD_BIN   = 8'd7,
  parameter logic [7:0] CMD_ASCII = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  input  logic [7:0] cmdCode,
  input  logic [7:0] cmdLen,
  output logic       cmdReady,
  input  logic [7:0] dataByte,
  input  logic       dataValid,
  output logic       dataReady,
  output logic       dataOut,
  output logic       frameStart,
  output logic       busy,
  output logic       illegalCmd,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, PEND, CMD, LEN, DATA} state_t;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, code_q, code_d, len_q, len_d, rem_q, rem_d;
  logic       ready_q, ready_d, ill_q, ill_d, und_q, und_d;
  logic       accept, legal, wrap, data_cmd, pull;
  logic [7:0] payload;
  always_comb begin
    accept    = cmdValid && cmdReady;
    legal     = cmdCode != 8'd0 && cmdCode <= 8'd8;
    wrap      = bit_cnt_q == 3'd7;
    data_cmd  = code_q == CMD_BIN || code_q == CMD_ASCII;
    pull      = wrap && (state_q == LEN || state_q == DATA) && rem_q != 8'd0;
    payload   = dataValid ? dataByte : 8'h00;
    bit_cnt_d = bit_cnt_q + 3'd1;
    ready_d   = 1'b1;
    state_d   = state_q;
    shift_d   = wrap ? IDLE_BYTE : {shift_q[6:0], 1'b0};
    code_d    = code_q;
    len_d     = len_q;
    rem_d     = rem_q;
    ill_d     = accept && !legal;
    und_d     = und_q || (pull && !dataValid);
    case (state_q)
      IDLE: if (accept && legal) begin
        code_d  = cmdCode;
        len_d   = cmdLen;
        state_d = wrap ? CMD : PEND;
        shift_d = wrap ? cmdCode : shift_d;
      end
      PEND: if (wrap) begin
        state_d = CMD;
        shift_d = code_q;
      end
      CMD: if (wrap) begin
        state_d = data_cmd ? LEN : IDLE;
        shift_d = data_cmd ? len_q : IDLE_BYTE;
        rem_d   = len_q;
      end
      LEN, DATA: if (wrap) begin
        state_d = pull ? DATA : IDLE;
        shift_d = pull ? payload : IDLE_BYTE;
        rem_d   = pull ? rem_q - 8'd1 : rem_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= IDLE_BYTE;
      code_q    <= 8'd0;
      len_q     <= 8'd0;
      rem_q     <= 8'd0;
      ready_q   <= 1'b0;
      ill_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      ready_q   <= ready_d;
      ill_q     <= ill_d;
      und_q     <= und_d;
    end
  end
  assign cmdReady   = ready_q && state_q == IDLE;
  assign dataReady  = pull;
  assign dataOut    = shift_q[7];
  assign frameStart = bit_cnt_q == 3'd0;
  assign busy       = state_q != IDLE;
  assign illegalCmd = ill_q;
  assign underrun   = und_q;
endmodule

// File: tb/tb_transfer_center_tx.sv
// tb_transfer_center_tx: directed checks of framing, command flow, payload pull and reset for transfer_center_tx.
module tb_transfer_center_tx;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmdValid = 1'b0, cmdReady, dataValid = 1'b1, dataReady;
  logic [7:0] cmdCode = 8'd0, cmdLen = 8'd0, dataByte;
  logic       dataOut, frameStart, busy, illegalCmd, underrun;
  logic [7:0] pay [8];
  int         pidx, tb_cnt, dr_cnt, dr_bad, acc_cnt;
  int         tests = 0, fails = 0;
  logic [7:0] f;
  int         w, bad_do, bad_fs, dr0, acc0;

  transfer_center_tx dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdCode(cmdCode), .cmdLen(cmdLen),
    .cmdReady(cmdReady), .dataByte(dataByte), .dataValid(dataValid), .dataReady(dataReady),
    .dataOut(dataOut), .frameStart(frameStart), .busy(busy), .illegalCmd(illegalCmd),
    .underrun(underrun)
  );

  always #5 clk = ~clk;
  assign dataByte = pay[pidx[2:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_cnt <= 0;
      pidx   <= 0;
    end else begin
      tb_cnt <= (tb_cnt + 1) % 8;
      if (dataReady) pidx <= pidx + 1;
    end
  end

  always @(negedge clk) if (!rst && dataReady) begin
    dr_cnt++;
    if (tb_cnt != 7) dr_bad++;
  end

  always @(posedge clk) if (!rst && cmdValid && cmdReady) acc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] code, input logic [7:0] len, input int b);
    int n = 0;
    @(negedge clk);
    while (tb_cnt != b && n < 16) begin
      @(negedge clk);
      n++;
    end
    cmdCode  = code;
    cmdLen   = len;
    cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic get_frame(output logic [7:0] fr, output int waits);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!frameStart && waits < 40);
    if (waits >= 40) chk("frame_timeout", 32'(waits), 32'd0);
    fr[7] = dataOut;
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      fr[i] = dataOut;
    end
  endtask

  initial begin
    dr_cnt = 0; dr_bad = 0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) pay[i] = 8'h00;
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[3] = 8'hA5;
    @(negedge clk);
    chk("rst_dataOut", 32'(dataOut), 32'd0);
    chk("rst_frameStart", 32'(frameStart), 32'd1);
    chk("rst_cmdReady", 32'(cmdReady), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad_do = 0; bad_fs = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (dataOut !== 1'b0) bad_do++;
      if (frameStart !== (i % 8 == 0)) bad_fs++;
    end
    chk("idle_dataOut_errs", 32'(bad_do), 32'd0);
    chk("idle_frameStart_errs", 32'(bad_fs), 32'd0);
    chk("idle_cmdReady", 32'(cmdReady), 32'd1);

    send_cmd(8'd3, 8'd0, 2);
    chk("cmd3_busy_pend", 32'(busy), 32'd1);
    get_frame(f, w);
    chk("cmd3_latency", 32'(w), 32'd6);
    chk("cmd3_frame", 32'(f), 32'h03);
    chk("cmd3_busy_last_bit", 32'(busy), 32'd1);
    get_frame(f, w);
    chk("cmd3_idle_frame", 32'(f), 32'h00);
    chk("cmd3_busy_after", 32'(busy), 32'd0);

    send_cmd(8'd0, 8'd0, 4);
    chk("ill0_pulse", 32'(illegalCmd), 32'd1);
    chk("ill0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("ill0_pulse_end", 32'(illegalCmd), 32'd0);
    send_cmd(8'd9, 8'd0, 1);
    chk("ill9_pulse", 32'(illegalCmd), 32'd1);
    @(posedge clk); #1;
    chk("ill9_pulse_end", 32'(illegalCmd), 32'd0);
    get_frame(f, w);
    chk("ill_idle_frame", 32'(f), 32'h00);

    send_cmd(8'd5, 8'd0, 7);
    chk("b7_busy", 32'(busy), 32'd1);
    get_frame(f, w);
    chk("b7_latency", 32'(w), 32'd1);
    chk("b7_frame", 32'(f), 32'h05);

    acc0 = acc_cnt;
    @(negedge clk);
    while (tb_cnt != 3) @(negedge clk);
    cmdCode = 8'd1; cmdLen = 8'd0; cmdValid = 1'b1;
    get_frame(f, w);
    cmdValid = 1'b0;
    chk("hold_frame", 32'(f), 32'h01);
    chk("hold_accepts", 32'(acc_cnt - acc0), 32'd1);
    @(negedge clk);
    chk("hold_busy_after", 32'(busy), 32'd0);

    dr0 = dr_cnt;
    send_cmd(8'd7, 8'd2, 5);
    get_frame(f, w); chk("bin_cmd", 32'(f), 32'h07);
    get_frame(f, w); chk("bin_len", 32'(f), 32'h02);
    get_frame(f, w); chk("bin_p0", 32'(f), 32'hA5);
    get_frame(f, w); chk("bin_p1", 32'(f), 32'h3C);
    get_frame(f, w); chk("bin_idle", 32'(f), 32'h00);
    chk("bin_strobes", 32'(dr_cnt - dr0), 32'd2);
    chk("bin_underrun", 32'(underrun), 32'd0);

    dr0 = dr_cnt;
    send_cmd(8'd8, 8'd0, 0);
    get_frame(f, w); chk("asc0_cmd", 32'(f), 32'h08);
    get_frame(f, w); chk("asc0_len", 32'(f), 32'h00);
    get_frame(f, w); chk("asc0_idle", 32'(f), 32'h00);
    chk("asc0_busy", 32'(busy), 32'd0);
    chk("asc0_strobes", 32'(dr_cnt - dr0), 32'd0);

    dataValid = 1'b0;
    send_cmd(8'd8, 8'd1, 6);
    get_frame(f, w); chk("und_cmd", 32'(f), 32'h08);
    get_frame(f, w); chk("und_len", 32'(f), 32'h01);
    get_frame(f, w); chk("und_payload", 32'(f), 32'h00);
    chk("und_flag", 32'(underrun), 32'd1);
    dataValid = 1'b1;
    get_frame(f, w);
    chk("und_sticky", 32'(underrun), 32'd1);
    chk("strobe_alignment_errs", 32'(dr_bad), 32'd0);

    send_cmd(8'd7, 8'd1, 1);
    get_frame(f, w); chk("mid_cmd", 32'(f), 32'h07);
    get_frame(f, w); chk("mid_len", 32'(f), 32'h01);
    w = 0;
    do begin @(negedge clk); w++; end while (!frameStart && w < 40);
    chk("mid_bit7", 32'(dataOut), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dataOut", 32'(dataOut), 32'd0);
    chk("mid_rst_frameStart", 32'(frameStart), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmdReady", 32'(cmdReady), 32'd0);
    chk("mid_rst_dataReady", 32'(dataReady), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmdReady", 32'(cmdReady), 32'd1);
    get_frame(f, w); chk("post_rst_idle", 32'(f), 32'h00);
    send_cmd(8'd1, 8'd0, 3);
    get_frame(f, w); chk("post_rst_cmd1", 32'(f), 32'h01);
    chk("post_rst_latency", 32'(w), 32'd5);
    get_frame(f, w); chk("post_rst_tail", 32'(f), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
